phase_frame_sequencer: RTL and testbench
========================================

// Module: phase_frame_sequencer
// PURPOSE
//  Front-end scheduler for the phase_ccgc pipeline. On start it scans one captured
//  pattern set (3 phase-shift images + 4 Gray-code images) from the frame store.
//  It binarises the Gray planes and drives aligned pixel streams, line strobes and the
//  frame strobe into phase_ccgc. Inserts line/frame blanking so per-line CCGC state settles.
// PARAMETERS
//  IMG_W        640  pixels per line
//  IMG_H        480  lines per frame
//  ADDR_W       19   frame-store address width (>= clog2(IMG_W*IMG_H))
//  RD_LAT       2    fixed frame-store read latency, cycles (>=1)
//  H_BLANK      16   idle cycles between lines; must be >= RD_LAT+2
//  V_BLANK      64   idle cycles after last line before done
//  GRAY_THRESH  128  Gray pixel >= GRAY_THRESH -> code bit 1
// PORTS
//  clk            in   1       system clock
//  rst            in   1       reset, asynchronous, active-low
//  start          in   1       1-cycle pulse; starts a frame scan when idle
//  abort          in   1       level; abandons scan
//  hold           in   1       downstream almost-full; pauses read issue
//  rd_en          out  1       frame-store read strobe
//  rd_addr        out  ADDR_W  linear pixel address row*IMG_W+col
//  rd_data        in   64      [7:0]ps1 [15:8]ps2 [23:16]ps3 [31:24]g1 [39:32]g2 [47:40]g3 [55:48]g4 [63:56]unused
//  phase_shift_1/2/3 out 8     phase-shift pixels, registered
//  line_hsync     out  1       pixel valid for phase path
//  hsync_k        out  1       pixel valid for CCGC path (== line_hsync)
//  ccp1_n..ccp4_n out  1 each  binarised g1..g4
//  ccp1_n_1       out  1       ccp1_n of previous pixel in same line; 0 at col 0
//  frame_vsync_k  out  1       frame active strobe
//  busy           out  1       state != IDLE
//  done           out  1       1-cycle pulse, frame completed normally
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, counters 0, all outputs 0, read pipeline flushed.
//  - FSM: IDLE -start-> LINE -last col issued-> HBLANK -count H_BLANK-> LINE (row+1)
//    or, after last row, -> VBLANK -count V_BLANK-> IDLE with done=1 for one cycle.
//  - start outside IDLE ignored. start and abort together in IDLE: abort wins, stay IDLE.
//  - LINE: rd_en=1 and col/rd_addr advance each cycle hold=0. When hold=1: rd_en=0,
//    address frozen, in-flight reads still complete. No pixel is dropped or duplicated.
//  - rd_en is delayed by an RD_LAT-deep valid shift register. Output regs load the cycle
//    rd_data is valid. Latency rd_en -> line_hsync = RD_LAT+1 cycles.
//  - ccpX_n = (gX >= GRAY_THRESH), unsigned 8-bit compare.
//  - ccp1_n_1 comes from a register updated only on valid output pixels.
//    It is cleared by a col==0 flag carried through the valid pipeline.
//  - Data outputs hold their last value while line_hsync=0.
//  - frame_vsync_k rises the cycle after start is accepted. It falls the cycle after the
//    last pixel (addr IMG_W*IMG_H-1) is output, i.e. inside VBLANK.
//  - rd_addr wraps to 0 only via IDLE; it never exceeds IMG_W*IMG_H-1.
//  - HBLANK counting starts the cycle after the last column issue. H_BLANK>=RD_LAT+2
//    guarantees the line drains before next issue, so line bursts never merge.
//  - abort (any non-IDLE state): next cycle state=IDLE, rd_en=0, valid pipeline cleared.
//    No further line_hsync, frame_vsync_k=0, done not pulsed.
//  - Single clock domain; no combinational path from inputs to outputs.
// TESTING
//  (bench params IMG_W=4 IMG_H=2 RD_LAT=2 H_BLANK=4 V_BLANK=4, GRAY_THRESH=128)
//  1 start, hold=0 -> rd_addr 0..3, gap, 4..7; two 4-pulse line_hsync bursts,
//    first pulse 3 cycles after first rd_en; one done; busy 0 after done.
//  2 g1 per pixel 127,128,255,0 -> ccp1_n 0,1,1,0; ps1..ps3 echo rd_data bytes exactly.
//  3 g1 = 200,10,200,10 both rows -> ccp1_n_1 0,1,0,1 in each row (cleared at col 0).
//  4 hold=1 for 3 cycles after addr 1 issued -> rd_addr stays 2, 3-cycle hsync gap,
//    still exactly 8 pixels in order.
//  5 abort after 3 reads -> busy=0 next cycle, no line_hsync after abort,
//    done never pulses; new start restarts at rd_addr 0.
//  6 rst low mid-line, then release and start -> outputs 0 during reset, clean full frame.

Source files
------------

// File: rtl/phase_frame_sequencer.sv
// phase_frame_sequencer: scans one pattern set from the frame store and streams aligned pixels into phase_ccgc
module phase_frame_sequencer #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int ADDR_W      = 19,
  parameter int RD_LAT      = 2,
  parameter int H_BLANK     = 16,
  parameter int V_BLANK     = 64,
  parameter int GRAY_THRESH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [63:0]       rd_data,
  output logic [7:0]        phase_shift_1,
  output logic [7:0]        phase_shift_2,
  output logic [7:0]        phase_shift_3,
  output logic              line_hsync,
  output logic              hsync_k,
  output logic              ccp1_n,
  output logic              ccp2_n,
  output logic              ccp3_n,
  output logic              ccp4_n,
  output logic              ccp1_n_1,
  output logic              frame_vsync_k,
  output logic              busy,
  output logic              done
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int BW = $clog2((H_BLANK > V_BLANK ? H_BLANK : V_BLANK) + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [BW-1:0] H_LAST   = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] V_LAST   = BW'(V_BLANK - 1);
  localparam logic [7:0]    THRESH   = 8'(GRAY_THRESH);

  typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [BW-1:0]     cnt;
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] first_col;
  logic [RD_LAT-1:0] last_pix;
  logic              last_out;
  logic              col_end;
  logic              row_end;
  logic              unused_bits;

  assign col_end     = col == COL_LAST;
  assign row_end     = row == ROW_LAST;
  assign busy        = state != IDLE;
  assign hsync_k     = line_hsync;
  assign unused_bits = ^rd_data[63:56];

  // Scan FSM: issues one read per unstalled LINE cycle; col/row always describe rd_addr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      cnt           <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      done          <= 1'b0;
      frame_vsync_k <= 1'b0;
    end else begin
      done <= 1'b0;
      if (line_hsync && last_out) frame_vsync_k <= 1'b0;
      if (abort) begin
        state         <= IDLE;
        rd_en         <= 1'b0;
        frame_vsync_k <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state         <= LINE;
            rd_en         <= !hold;
            rd_addr       <= '0;
            col           <= '0;
            row           <= '0;
            frame_vsync_k <= 1'b1;
          end
          LINE: if (rd_en && col_end) begin
            rd_en <= 1'b0;
            cnt   <= '0;
            col   <= '0;
            state <= row_end ? VBLANK : HBLANK;
            if (!row_end) begin
              row     <= row + 1'b1;
              rd_addr <= rd_addr + 1'b1;
            end
          end else begin
            rd_en <= !hold;
            if (rd_en) begin
              col     <= col + 1'b1;
              rd_addr <= rd_addr + 1'b1;
            end
          end
          HBLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == H_LAST) begin
              state <= LINE;
              rd_en <= !hold;
            end
          end
          VBLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == V_LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Read-latency pipeline: valid, col-0 and last-pixel flags travel with each read; outputs load when data lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld           <= '0;
      first_col     <= '0;
      last_pix      <= '0;
      last_out      <= 1'b0;
      line_hsync    <= 1'b0;
      phase_shift_1 <= '0;
      phase_shift_2 <= '0;
      phase_shift_3 <= '0;
      ccp1_n        <= 1'b0;
      ccp2_n        <= 1'b0;
      ccp3_n        <= 1'b0;
      ccp4_n        <= 1'b0;
      ccp1_n_1      <= 1'b0;
    end else begin
      vld        <= abort ? '0 : RD_LAT'({vld, rd_en});
      first_col  <= RD_LAT'({first_col, col == '0});
      last_pix   <= RD_LAT'({last_pix, col_end && row_end});
      line_hsync <= !abort && vld[RD_LAT-1];
      if (vld[RD_LAT-1] && !abort) begin
        phase_shift_1 <= rd_data[7:0];
        phase_shift_2 <= rd_data[15:8];
        phase_shift_3 <= rd_data[23:16];
        ccp1_n        <= rd_data[31:24] >= THRESH;
        ccp2_n        <= rd_data[39:32] >= THRESH;
        ccp3_n        <= rd_data[47:40] >= THRESH;
        ccp4_n        <= rd_data[55:48] >= THRESH;
        ccp1_n_1      <= !first_col[RD_LAT-1] && ccp1_n;
        last_out      <= last_pix[RD_LAT-1];
      end
    end
  end
endmodule

// File: tb/tb_phase_frame_sequencer.sv
// tb_phase_frame_sequencer: directed table-driven bench for phase_frame_sequencer on a 4x2 frame
module tb_phase_frame_sequencer;
  localparam int W = 4, H = 2, AW = 3, LAT = 2, HB = 4, VB = 4;

  typedef struct {
    logic [7:0] p1, p2, p3, g1, g2, g3, g4;
    logic [3:0] ccp;
    logic       prev;
  } vec_t;

  typedef struct {
    logic [7:0] p1, p2, p3;
    logic [3:0] ccp;
    logic       prev;
    int         c;
  } pix_t;

  logic clk, rst, start, abort, hold;
  logic rd_en, line_hsync, hsync_k, ccp1_n, ccp2_n, ccp3_n, ccp4_n, ccp1_n_1;
  logic frame_vsync_k, busy, done;
  logic [AW-1:0] rd_addr;
  logic [63:0] rd_data;
  logic [7:0] phase_shift_1, phase_shift_2, phase_shift_3;

  phase_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(LAT),
    .H_BLANK(HB), .V_BLANK(VB), .GRAY_THRESH(128)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .phase_shift_1(phase_shift_1), .phase_shift_2(phase_shift_2), .phase_shift_3(phase_shift_3),
    .line_hsync(line_hsync), .hsync_k(hsync_k),
    .ccp1_n(ccp1_n), .ccp2_n(ccp2_n), .ccp3_n(ccp3_n), .ccp4_n(ccp4_n), .ccp1_n_1(ccp1_n_1),
    .frame_vsync_k(frame_vsync_k), .busy(busy), .done(done)
  );

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc, rise_cyc, fall_cyc, done_cyc, done_cnt;
  logic vs_q = 1'b0;
  vec_t vec [3][8];
  logic [63:0] mem [8];
  logic [AW-1:0] ap0, ap1;
  pix_t pix_q [$];
  logic [AW-1:0] iss_a [$];
  int iss_c [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ap0 <= rd_addr;
    ap1 <= ap0;
  end
  assign rd_data = mem[ap1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    pix_t p;
    chk("hsync_k_eq_line_hsync", hsync_k, line_hsync);
    if (rd_en) begin
      iss_a.push_back(rd_addr);
      iss_c.push_back(cyc);
    end
    if (line_hsync) begin
      p.p1 = phase_shift_1; p.p2 = phase_shift_2; p.p3 = phase_shift_3;
      p.ccp = {ccp4_n, ccp3_n, ccp2_n, ccp1_n};
      p.prev = ccp1_n_1;
      p.c = cyc;
      pix_q.push_back(p);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_vsync_k && !vs_q) rise_cyc = cyc;
    if (!frame_vsync_k && vs_q) fall_cyc = cyc;
    vs_q = frame_vsync_k;
  end

  task automatic load_frame(input int f);
    for (int i = 0; i < 8; i++)
      mem[i] = {8'h5A, vec[f][i].g4, vec[f][i].g3, vec[f][i].g2, vec[f][i].g1,
                vec[f][i].p3, vec[f][i].p2, vec[f][i].p1};
  endtask

  task automatic clear_logs();
    pix_q.delete();
    iss_a.delete();
    iss_c.delete();
    done_cnt = 0;
    rise_cyc = -1;
    fall_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic start_frame(input int f);
    load_frame(f);
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    start_cyc = cyc;
  endtask

  // mode 0: plain, 1: hold for 3 cycles after addr 1 issue, 2: stray start mid-frame
  task automatic wait_done(input int mode);
    bit seen = 0, hd = 0;
    int hc = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mode == 1) begin
        if (hc > 0) begin
          chk("hold_addr_frozen", {rd_en, rd_addr}, {1'b0, 3'd2});
          hc--;
          if (hc == 0) hold = 1'b0;
        end else if (!hd && rd_en && rd_addr == 3'd1) begin
          hold = 1'b1;
          hc = 3;
          hd = 1;
        end
      end
      if (mode == 2) start = (i == 5);
      seen = done;
    end
    start = 1'b0;
    hold = 1'b0;
    chk("done_within_budget", seen, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input int f);
    chk("pixel_count", pix_q.size(), 8);
    chk("issue_count", iss_a.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < iss_a.size()) chk($sformatf("issue_addr[%0d]", i), iss_a[i], i);
      if (i < pix_q.size()) begin
        chk($sformatf("ps[%0d]", i), {pix_q[i].p1, pix_q[i].p2, pix_q[i].p3},
            {vec[f][i].p1, vec[f][i].p2, vec[f][i].p3});
        chk($sformatf("ccp[%0d]", i), pix_q[i].ccp, vec[f][i].ccp);
        chk($sformatf("ccp1_n_1[%0d]", i), pix_q[i].prev, vec[f][i].prev);
        if (i < iss_c.size()) chk($sformatf("latency[%0d]", i), pix_q[i].c - iss_c[i], LAT + 1);
      end
    end
    if (iss_c.size() == 8) begin
      chk("first_issue_cycle", iss_c[0], start_cyc);
      chk("hblank_gap", iss_c[4] - iss_c[3], HB + 1);
      chk("vblank_to_done", done_cyc - iss_c[7], VB + 1);
    end
    if (pix_q.size() == 8) chk("vsync_fall", fall_cyc, pix_q[7].c + 1);
    chk("vsync_rise", rise_cyc, start_cyc);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", busy, 0);
    chk("vsync_after_done", frame_vsync_k, 0);
  endtask

  initial begin
    int n;
    vec[0][0] = '{8'd11, 8'd22, 8'd33, 8'd127, 8'd128, 8'd0,   8'd255, 4'b1010, 1'b0};
    vec[0][1] = '{8'd44, 8'd55, 8'd66, 8'd128, 8'd127, 8'd129, 8'd1,   4'b0101, 1'b0};
    vec[0][2] = '{8'd77, 8'd88, 8'd99, 8'd255, 8'd255, 8'd255, 8'd255, 4'b1111, 1'b1};
    vec[0][3] = '{8'd0,  8'd255, 8'd128, 8'd0, 8'd0,   8'd0,   8'd0,   4'b0000, 1'b1};
    vec[0][4] = '{8'd1,  8'd2,  8'd3,  8'd200, 8'd64,  8'd192, 8'd128, 4'b1101, 1'b0};
    vec[0][5] = '{8'd4,  8'd5,  8'd6,  8'd10,  8'd130, 8'd100, 8'd127, 4'b0010, 1'b1};
    vec[0][6] = '{8'd7,  8'd8,  8'd9,  8'd200, 8'd0,   8'd128, 8'd250, 4'b1101, 1'b0};
    vec[0][7] = '{8'd10, 8'd20, 8'd30, 8'd10,  8'd255, 8'd1,   8'd0,   4'b0010, 1'b1};
    for (int i = 0; i < 8; i++) begin
      vec[1][i] = '{8'(i * 17 + 5), 8'(255 - i), 8'(i << 4), (i % 2) ? 8'd10 : 8'd200,
                    8'd0, 8'd0, 8'd0, (i % 2) ? 4'b0000 : 4'b0001, 1'((i % 2) == 1)};
      vec[2][i] = '{8'(i + 100), 8'(i + 150), 8'(i + 200), 8'd200,
                    8'd128, 8'd255, 8'd130, 4'b1111, 1'((i % 4) != 0)};
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    load_frame(0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_en, rd_addr, phase_shift_1, phase_shift_2, phase_shift_3, line_hsync,
        ccp1_n, ccp2_n, ccp3_n, ccp4_n, ccp1_n_1, frame_vsync_k, busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);

    start_frame(0);
    wait_done(0);
    check_frame(0);

    start_frame(1);
    wait_done(2);
    check_frame(1);

    start_frame(2);
    wait_done(1);
    check_frame(2);
    if (pix_q.size() == 8) chk("hold_hsync_gap", pix_q[2].c - pix_q[1].c, 4);
    if (iss_c.size() == 8) chk("hold_issue_gap", iss_c[2] - iss_c[1], 4);

    load_frame(0);
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = rd_en;
    for (int i = 0; i < 50 && n < 3; i++) begin
      @(negedge clk);
      n += rd_en;
    end
    chk("reads_before_abort", n, 3);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_vsync", frame_vsync_k, 0);
    abort = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_hsync", pix_q.size(), 0);
    chk("abort_issue_count", iss_a.size(), 3);
    chk("abort_no_done", done_cnt, 0);

    clear_logs();
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_idle_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("start_abort_no_reads", iss_a.size(), 0);

    start_frame(0);
    wait_done(0);
    check_frame(0);

    load_frame(1);
    clear_logs();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 50 && !(rd_en && rd_addr == 3'd6); i++) @(negedge clk);
    chk("mid_frame_pixels_seen", pix_q.size(), 4);
    #1 rst = 1'b0;
    #1 chk("async_reset_outputs", {rd_en, rd_addr, phase_shift_1, phase_shift_2, phase_shift_3,
        line_hsync, ccp1_n, ccp2_n, ccp3_n, ccp4_n, ccp1_n_1, frame_vsync_k, busy, done}, 0);
    repeat (2) @(negedge clk);
    chk("reset_held_outputs", {rd_en, line_hsync, frame_vsync_k, busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);
    start_frame(1);
    wait_done(0);
    check_frame(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
